seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have ports, clock and reset first:
  clk      input   1   system clock, same clock as the CPU core
  reset    input   1   synchronous reset, active-high
  hex      input   32  syscall display value from the CPU
  cnt_clk  input   11  clock-cycle statistics counter
  cnt_i    input   11  I-type instruction counter
  cnt_r    input   11  R-type instruction counter
  cnt_j    input   11  J-type instruction counter
  sel      input   3   source select: 0 hex, 1 cnt_clk, 2 cnt_i, 3 cnt_r, 4 cnt_j, 5-7 hex
  an       output  8   digit enables, active-low, an[0] = rightmost digit
  seg      output  8   {dp,g,f,e,d,c,b,a}, active-low
REQ-003 SHALL use one clock domain (clk); reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL count div_cnt 0..SCAN_DIV-1 and wrap; digit index SHALL advance by 1 when div_cnt = SCAN_DIV-1.
REQ-005 Digit index SHALL wrap from 7 to 0; a frame is one pass over digits 0..7 (8*SCAN_DIV cycles).
REQ-006 SHALL snapshot sel and the selected source into a shadow register at frame start only: on the first cycle after reset release, and on every 7->0 digit wrap. Inputs changing mid-frame SHALL NOT alter the displayed frame.
REQ-007 an SHALL be ~(8'b1 << digit); exactly one bit low outside reset.
REQ-008 Hex mode (sel 0, 5-7): digit k SHALL show nibble shadow[4k+3:4k] in hex.
REQ-009 Counter mode (sel 1-4): digits 0-3 SHALL show the counter value; digits 4-7 SHALL be blank (seg = 8'hFF).
REQ-010 Encoding, seg[6:0]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-011 dp (seg[7]) SHALL be 1 (off) except on digit 4 in counter mode, where it is 0 as a mode marker.
REQ-012 an and seg SHALL be registered, lagging the digit index by exactly 1 cycle.
REQ-013 Leading zeros SHALL be displayed; no zero suppression.

Reset
REQ-014 While reset = 1: div_cnt = 0, digit = 0, shadow = 0, an = 8'hFF, seg = 8'hFF, BCD result = 0, converter idle.
REQ-015 Reset asserted mid-frame or mid-conversion SHALL abort immediately; no partial result is kept.
REQ-016 On the first cycle after reset release: snapshot taken. On the second cycle: an = 8'hFE, seg shows digit 0 of the snapshot.

Configuration
REQ-017 Macro SEG_BCD_EN.
  - Defined: counter mode SHALL show decimal 0000..2047.
    * A sequential shift-add-3 converter SHALL start on the counter snapshot and finish in exactly 11 cycles.
    * Until it finishes, digits 0-3 SHALL show the previous BCD result.
    * The new result SHALL be latched on its 11th cycle.
    * sel change during conversion SHALL have no effect.
  - Undefined: counter mode SHALL show the zero-extended 11-bit value as 4 hex digits (000..7FF); no converter logic SHALL be synthesised.
  - Hex mode SHALL be identical in both builds.

Verification (SCAN_DIV=2)
REQ-018 Reset 3 cycles, hex=32'h1234ABCD, sel=0 -> digits 0..7 show D,C,b,A,4,3,2,1; each an code held 2 cycles; an sequence FE,FD,...,7F repeats.
REQ-019 sel=0, hex changed to 32'hFFFFFFFF while digit 3 is active -> current frame unchanged; next frame all digits seg=8'h8E.
REQ-020 sel=2, cnt_i=11'd1234, SEG_BCD_EN defined -> from frame 2 digits 0-3 show 4,3,2,1; digit 4 seg=8'h7F; digits 5-7 seg=8'hFF.
REQ-021 Same stimulus with SEG_BCD_EN undefined -> digits 0-3 show 2,D,4,0 (11'h4D2).
REQ-022 cnt_clk=11'd2047, sel=1, BCD build -> 7,4,0,2; reset pulsed at converter cycle 5 -> an=seg=8'hFF during reset; after release shows 2047 again with no stale digits.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// 8-digit multiplexed 7-segment driver: hex word or one of four 11-bit counters, build option SEG_BCD_EN.
// Latency: an/seg are registered one cycle behind the digit index; inputs are sampled once per frame.
// Backpressure: none; inputs are free-running levels snapshotted at frame start.
module seg_display_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hex,
    input  logic [10:0] cnt_clk,
    input  logic [10:0] cnt_i,
    input  logic [10:0] cnt_r,
    input  logic [10:0] cnt_j,
    input  logic [2:0]  sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] div_cnt;
    logic [2:0]  digit;
    logic        live;
    logic [31:0] shadow;
    logic        cnt_mode;
    logic        frame_start;
    logic        src_is_cnt;
    logic [10:0] src_cnt;
    logic [15:0] disp_cnt;
    logic [3:0]  nib;
    logic        dp;
    logic        blank;
    logic [7:0]  seg_nxt;

    function automatic logic [6:0] enc7(input logic [3:0] v);
        case (v)
            4'h0: enc7 = 7'b1000000;
            4'h1: enc7 = 7'b1111001;
            4'h2: enc7 = 7'b0100100;
            4'h3: enc7 = 7'b0110000;
            4'h4: enc7 = 7'b0011001;
            4'h5: enc7 = 7'b0010010;
            4'h6: enc7 = 7'b0000010;
            4'h7: enc7 = 7'b1111000;
            4'h8: enc7 = 7'b0000000;
            4'h9: enc7 = 7'b0010000;
            4'hA: enc7 = 7'b0001000;
            4'hB: enc7 = 7'b0000011;
            4'hC: enc7 = 7'b1000110;
            4'hD: enc7 = 7'b0100001;
            4'hE: enc7 = 7'b0000110;
            default: enc7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        src_is_cnt = 1'b1;
        src_cnt    = 11'd0;
        case (sel)
            3'd1:    src_cnt = cnt_clk;
            3'd2:    src_cnt = cnt_i;
            3'd3:    src_cnt = cnt_r;
            3'd4:    src_cnt = cnt_j;
            default: src_is_cnt = 1'b0;
        endcase
    end

    // The first live cycle after reset doubles as the first frame start.
    assign frame_start = !live || (div_cnt == DIV_LAST && digit == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            digit    <= '0;
            live     <= 1'b0;
            shadow   <= '0;
            cnt_mode <= 1'b0;
        end else begin
            live <= 1'b1;
            if (live) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    digit   <= digit + 3'd1;
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
            if (frame_start) begin
                shadow   <= src_is_cnt ? {21'd0, src_cnt} : hex;
                cnt_mode <= src_is_cnt;
            end
        end
    end

`ifdef SEG_BCD_EN
    logic [10:0] conv_bin;
    logic [15:0] conv_bcd;
    logic [15:0] conv_adj;
    logic [15:0] conv_nxt;
    logic [3:0]  conv_cnt;
    logic        conv_busy;
    logic [15:0] bcd_result;

    // Shift-add-3: bias every BCD nibble of 5 or more before the next left shift.
    always_comb begin
        conv_adj = conv_bcd;
        for (int i = 0; i < 4; i++) begin
            if (conv_bcd[4*i +: 4] >= 4'd5)
                conv_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
        end
        conv_nxt = 16'({conv_adj, conv_bin[10]});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_bin   <= '0;
            conv_bcd   <= '0;
            conv_cnt   <= '0;
            conv_busy  <= 1'b0;
            bcd_result <= '0;
        end else if (frame_start && src_is_cnt) begin
            conv_bin  <= src_cnt;
            conv_bcd  <= '0;
            conv_cnt  <= '0;
            conv_busy <= 1'b1;
        end else if (conv_busy) begin
            conv_bin <= {conv_bin[9:0], 1'b0};
            conv_bcd <= conv_nxt;
            if (conv_cnt == 4'd10) begin
                bcd_result <= conv_nxt;
                conv_busy  <= 1'b0;
            end else begin
                conv_cnt <= conv_cnt + 4'd1;
            end
        end
    end

    assign disp_cnt = bcd_result;
`else
    assign disp_cnt = shadow[15:0];
`endif

    always_comb begin
        nib   = shadow[{digit, 2'b00} +: 4];
        dp    = 1'b1;
        blank = 1'b0;
        if (cnt_mode) begin
            if (digit[2]) begin
                blank = 1'b1;
                dp    = (digit != 3'd4);
            end else begin
                nib = disp_cnt[{digit[1:0], 2'b00} +: 4];
            end
        end
        seg_nxt = blank ? {dp, 7'h7F} : {dp, enc7(nib)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else if (live) begin
            an  <= ~(8'b1 << digit);
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboarded bench for seg_display_ctrl (SCAN_DIV=2): frame-level reference model feeds an expected queue.
module tb_seg_display_ctrl;
    localparam int SD = 2;
`ifdef SEG_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] hex = 32'h0;
    logic [10:0] cnt_clk = '0, cnt_i = '0, cnt_r = '0, cnt_j = '0;
    logic [2:0]  sel = '0;
    logic [7:0]  an, seg;

    seg_display_ctrl #(.SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .hex(hex), .cnt_clk(cnt_clk), .cnt_i(cnt_i),
        .cnt_r(cnt_r), .cnt_j(cnt_j), .sel(sel), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    logic [6:0] enc [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic logic [7:0] exp_seg(input int d, input logic cm, input logic [31:0] v, input int dec);
        int n;
        int p10;
        if (cm && d >= 4) return (d == 4) ? 8'h7F : 8'hFF;
        if (cm && BCD) begin
            p10 = 1;
            for (int i = 0; i < d; i++) p10 = p10 * 10;
            n = (dec / p10) % 10;
        end else begin
            n = int'((v >> (4 * d)) & 32'hF);
        end
        return {1'b1, enc[n]};
    endfunction

    // Reference model: t counts edges since reset release; frame f is snapshotted at edge 1+8*SD*f.
    int          t = 0;
    int          ready_t = -1;
    int          bcd_shown = 0;
    int          bcd_next = 0;
    logic        snap_cm = 1'b0;
    logic [31:0] snap_val = '0;
    logic [15:0] model_e;
    int          pos, dg;
    logic        in_cm;
    logic [10:0] in_cnt;

    always @(posedge clk) begin
        if (reset) begin
            t = 0; ready_t = -1; bcd_shown = 0; snap_cm = 1'b0; snap_val = '0;
            model_e = 16'hFFFF;
        end else begin
            t = t + 1;
            if (t == 1) begin
                model_e = 16'hFFFF;
            end else begin
                pos = t - 2;
                dg = (pos / SD) % 8;
                model_e = {~(8'd1 << dg), exp_seg(dg, snap_cm, snap_val, bcd_shown)};
            end
            if (t == ready_t) bcd_shown = bcd_next;
            if (t == 1 || (t - 1) % (8 * SD) == 0) begin
                in_cm = (sel >= 3'd1 && sel <= 3'd4);
                in_cnt = (sel == 3'd1) ? cnt_clk : (sel == 3'd2) ? cnt_i :
                         (sel == 3'd3) ? cnt_r : cnt_j;
                snap_cm = in_cm;
                snap_val = in_cm ? {21'd0, in_cnt} : hex;
                if (in_cm) begin
                    bcd_next = int'(in_cnt);
                    ready_t = t + 11;
                end
            end
        end
        exp_q.push_back(model_e);
    end

    logic [15:0] mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total = total + 2;
            if (an !== mon_e[15:8]) begin
                bad = bad + 1;
                $display("FAIL an at %0t: got %h want %h", $time, an, mon_e[15:8]);
            end
            if (seg !== mon_e[7:0]) begin
                bad = bad + 1;
                $display("FAIL seg at %0t: got %h want %h (an want %h)", $time, seg, mon_e[7:0], mon_e[15:8]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        hex = 32'h1234ABCD; sel = 3'd0; reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(16 + 8);
        hex = 32'hFFFFFFFF;
        step(40);
        sel = 3'd2; cnt_i = 11'd1234;
        step(52);
        sel = 3'd1; cnt_clk = 11'd2047;
        step(40);
        reset = 1'b1; step(2); reset = 1'b0;
        step(22);
        reset = 1'b1; step(3); reset = 1'b0;
        step(60);
        repeat (80) begin
            hex = $urandom; sel = 3'($urandom);
            cnt_clk = 11'($urandom); cnt_i = 11'($urandom);
            cnt_r = 11'($urandom); cnt_j = 11'($urandom);
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1; step($urandom_range(1, 3)); reset = 1'b0;
            end
            step($urandom_range(1, 24));
        end
        step(4);
        total = total + 1;
        if (total < 500) begin
            bad = bad + 1;
            $display("FAIL check_count: got %0d want at least 500", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
